// File: rtl/rename_stage.sv
// Two-wide register rename: speculative/retirement RATs and a circular free list.
// Renamed groups are registered toward dispatch one cycle after acceptance.
package rename_pkg;
    localparam int PW = 6;

    typedef struct packed {
        logic [6:0]    opcode;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [PW-1:0] prd;
        logic [PW-1:0] prs1;
        logic [PW-1:0] prs2;
        logic [PW-1:0] old_prd;
    } instruction_t;
endpackage

module rename_stage
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int PHY_REGS  = 64,
    parameter int PHY_WIDTH = 6,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           decode_valid,
    input  instruction_t         decode_instruction_0,
    input  instruction_t         decode_instruction_1,
    input  logic                 rob_ready,
    input  logic [ROB_WIDTH-1:0] rob_id_0,
    input  logic [ROB_WIDTH-1:0] rob_id_1,
    output logic                 rename_ready,
    output logic [1:0]           rename_valid,
    output instruction_t         rename_instruction_0,
    output instruction_t         rename_instruction_1,
    output logic [ROB_WIDTH-1:0] rob_id_out_0,
    output logic [ROB_WIDTH-1:0] rob_id_out_1,
    output logic [1:0]           alloc_valid,
    output logic [PHY_WIDTH-1:0] alloc_prd_0,
    output logic [PHY_WIDTH-1:0] alloc_prd_1,
    input  logic [1:0]           commit_valid,
    input  logic [4:0]           commit_rd_0,
    input  logic [4:0]           commit_rd_1,
    input  logic [PHY_WIDTH-1:0] commit_prd_0,
    input  logic [PHY_WIDTH-1:0] commit_prd_1,
    input  logic [PHY_WIDTH-1:0] commit_old_prd_0,
    input  logic [PHY_WIDTH-1:0] commit_old_prd_1,
    input  logic                 flush
);
    localparam int FL_DEPTH = PHY_REGS - ARCH_REGS;
    localparam int FL_W     = $clog2(FL_DEPTH);

    typedef logic [FL_W:0] ptr_t;

    logic [PHY_WIDTH-1:0] rat       [ARCH_REGS];
    logic [PHY_WIDTH-1:0] rrat      [ARCH_REGS];
    logic [PHY_WIDTH-1:0] rrat_next [ARCH_REGS];
    logic [PHY_WIDTH-1:0] fl        [FL_DEPTH];

    ptr_t head, tail, committed_head;
    ptr_t head_1, tail_1, committed_head_next, free_count;

    instruction_t ins0, ins1, ren0, ren1;
    logic         alloc0, alloc1, byp, accept, cm0, cm1;
    logic [1:0]   need;
    logic [PHY_WIDTH-1:0] new_prd0, new_prd1;

    always_comb begin
        ins0       = decode_instruction_0;
        ins1       = decode_instruction_1;
        alloc0     = decode_valid[0] && (ins0.rd != 5'd0);
        alloc1     = decode_valid[1] && (ins1.rd != 5'd0);
        need       = {1'b0, alloc0} + {1'b0, alloc1};
        free_count = tail - head;
        rename_ready = !rst && !flush && rob_ready &&
                       (free_count >= ptr_t'(need));
        accept     = rename_ready && (decode_valid != 2'b00);
        head_1     = head + ptr_t'(alloc0);
        new_prd0   = fl[head[FL_W-1:0]];
        new_prd1   = fl[head_1[FL_W-1:0]];
        // only an allocating slot 0 can feed slot 1
        byp        = alloc0;

        ren0         = ins0;
        ren0.prs1    = (ins0.rs1 == 5'd0) ? '0 : rat[ins0.rs1];
        ren0.prs2    = (ins0.rs2 == 5'd0) ? '0 : rat[ins0.rs2];
        ren0.prd     = alloc0 ? new_prd0 : '0;
        ren0.old_prd = alloc0 ? rat[ins0.rd] : '0;

        ren1      = ins1;
        ren1.prs1 = (ins1.rs1 == 5'd0) ? '0 :
                    (byp && ins1.rs1 == ins0.rd) ? new_prd0 :
                    rat[ins1.rs1];
        ren1.prs2 = (ins1.rs2 == 5'd0) ? '0 :
                    (byp && ins1.rs2 == ins0.rd) ? new_prd0 :
                    rat[ins1.rs2];
        ren1.prd  = alloc1 ? new_prd1 : '0;
        ren1.old_prd = !alloc1 ? '0 :
                       (byp && ins1.rd == ins0.rd) ? new_prd0 :
                       rat[ins1.rd];
    end

    always_comb begin
        cm0       = commit_valid[0] && (commit_rd_0 != 5'd0);
        cm1       = commit_valid[1] && (commit_rd_1 != 5'd0);
        tail_1    = tail + ptr_t'(cm0);
        committed_head_next = committed_head + ptr_t'(cm0) + ptr_t'(cm1);
        rrat_next = rrat;
        if (cm0) rrat_next[commit_rd_0] = commit_prd_0;
        if (cm1) rrat_next[commit_rd_1] = commit_prd_1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i]  <= PHY_WIDTH'(i);
                rrat[i] <= PHY_WIDTH'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= PHY_WIDTH'(ARCH_REGS + i);
            end
            head                 <= '0;
            committed_head       <= '0;
            tail                 <= ptr_t'(FL_DEPTH);
            rename_valid         <= '0;
            rename_instruction_0 <= '0;
            rename_instruction_1 <= '0;
            rob_id_out_0         <= '0;
            rob_id_out_1         <= '0;
            alloc_valid          <= '0;
            alloc_prd_0          <= '0;
            alloc_prd_1          <= '0;
        end else begin
            if (cm0) fl[tail[FL_W-1:0]]   <= commit_old_prd_0;
            if (cm1) fl[tail_1[FL_W-1:0]] <= commit_old_prd_1;
            tail           <= tail_1 + ptr_t'(cm1);
            committed_head <= committed_head_next;
            rrat           <= rrat_next;

            // flush restores from the post-commit retirement view
            if (flush) begin
                rat  <= rrat_next;
                head <= committed_head_next;
            end else if (accept) begin
                if (alloc0) rat[ins0.rd] <= new_prd0;
                if (alloc1) rat[ins1.rd] <= new_prd1;
                head <= head_1 + ptr_t'(alloc1);
            end

            rename_valid <= accept ? decode_valid : 2'b00;
            alloc_valid  <= accept ? {alloc1, alloc0} : 2'b00;
            if (accept) begin
                rename_instruction_0 <= ren0;
                rename_instruction_1 <= ren1;
                rob_id_out_0         <= rob_id_0;
                rob_id_out_1         <= rob_id_1;
                alloc_prd_0          <= ren0.prd;
                alloc_prd_1          <= ren1.prd;
            end
        end
    end
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: bypass, same-rd, exhaustion,
// flush recovery, x0 handling and reset.
module tb_rename_stage;
    import rename_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   decode_valid;
    instruction_t decode_instruction_0, decode_instruction_1;
    logic         rob_ready;
    logic [3:0]   rob_id_0, rob_id_1;
    logic         rename_ready;
    logic [1:0]   rename_valid;
    instruction_t rename_instruction_0, rename_instruction_1;
    logic [3:0]   rob_id_out_0, rob_id_out_1;
    logic [1:0]   alloc_valid;
    logic [5:0]   alloc_prd_0, alloc_prd_1;
    logic [1:0]   commit_valid;
    logic [4:0]   commit_rd_0, commit_rd_1;
    logic [5:0]   commit_prd_0, commit_prd_1;
    logic [5:0]   commit_old_prd_0, commit_old_prd_1;
    logic         flush;

    int checks = 0;
    int failures = 0;

    rename_stage dut (
        .clk(clk), .rst(rst),
        .decode_valid(decode_valid),
        .decode_instruction_0(decode_instruction_0),
        .decode_instruction_1(decode_instruction_1),
        .rob_ready(rob_ready),
        .rob_id_0(rob_id_0), .rob_id_1(rob_id_1),
        .rename_ready(rename_ready),
        .rename_valid(rename_valid),
        .rename_instruction_0(rename_instruction_0),
        .rename_instruction_1(rename_instruction_1),
        .rob_id_out_0(rob_id_out_0), .rob_id_out_1(rob_id_out_1),
        .alloc_valid(alloc_valid),
        .alloc_prd_0(alloc_prd_0), .alloc_prd_1(alloc_prd_1),
        .commit_valid(commit_valid),
        .commit_rd_0(commit_rd_0), .commit_rd_1(commit_rd_1),
        .commit_prd_0(commit_prd_0), .commit_prd_1(commit_prd_1),
        .commit_old_prd_0(commit_old_prd_0),
        .commit_old_prd_1(commit_old_prd_1),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic instruction_t mk(input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        instruction_t t;
        t        = '0;
        t.opcode = 7'h33;
        t.rd     = rd;
        t.rs1    = rs1;
        t.rs2    = rs2;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        decode_valid = 2'b00;
        decode_instruction_0 = '0;
        decode_instruction_1 = '0;
        commit_valid = 2'b00;
        commit_rd_0 = '0; commit_rd_1 = '0;
        commit_prd_0 = '0; commit_prd_1 = '0;
        commit_old_prd_0 = '0; commit_old_prd_1 = '0;
        flush = 1'b0;
        rob_ready = 1'b1;
        rob_id_0 = '0; rob_id_1 = '0;
    endtask

    task automatic group(input logic [1:0] v, input instruction_t a,
                         input instruction_t b);
        decode_valid = v;
        decode_instruction_0 = a;
        decode_instruction_1 = b;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        group(2'b11, mk(1, 2, 3), mk(4, 1, 1));
        tick();
        tick();
        check("ready_in_rst", rename_ready, 0);
        idle();
        rst = 1'b0;
        #1;
        check("rst_valid", rename_valid, 0);
        check("rst_alloc", alloc_valid, 0);
        check("rst_ins0", rename_instruction_0, 0);
        check("rst_ready", rename_ready, 1);

        // bypass group
        group(2'b11, mk(1, 2, 3), mk(4, 1, 1));
        rob_ready = 1'b0;
        #1 check("rob_block", rename_ready, 0);
        rob_ready = 1'b1;
        rob_id_0 = 4'd3; rob_id_1 = 4'd4;
        #1 check("byp_ready", rename_ready, 1);
        tick();
        idle();
        check("byp_valid", rename_valid, 3);
        check("byp_p0_prs1", rename_instruction_0.prs1, 2);
        check("byp_p0_prs2", rename_instruction_0.prs2, 3);
        check("byp_p0_prd", rename_instruction_0.prd, 32);
        check("byp_p0_old", rename_instruction_0.old_prd, 1);
        check("byp_p1_prs1", rename_instruction_1.prs1, 32);
        check("byp_p1_prs2", rename_instruction_1.prs2, 32);
        check("byp_p1_prd", rename_instruction_1.prd, 33);
        check("byp_p1_old", rename_instruction_1.old_prd, 4);
        check("byp_alloc", alloc_valid, 3);
        check("byp_aprd0", alloc_prd_0, 32);
        check("byp_aprd1", alloc_prd_1, 33);
        check("byp_rob0", rob_id_out_0, 3);
        check("byp_rob1", rob_id_out_1, 4);
        tick();
        check("byp_gap", rename_valid, 0);

        // same rd pair
        do_reset();
        group(2'b11, mk(5, 1, 0), mk(5, 5, 0));
        tick();
        check("srd_p0_prd", rename_instruction_0.prd, 32);
        check("srd_p0_old", rename_instruction_0.old_prd, 5);
        check("srd_p1_prs1", rename_instruction_1.prs1, 32);
        check("srd_p1_prd", rename_instruction_1.prd, 33);
        check("srd_p1_old", rename_instruction_1.old_prd, 32);
        group(2'b01, mk(6, 5, 5), mk(0, 0, 0));
        tick();
        idle();
        check("srd_rat5", rename_instruction_0.prs1, 33);
        check("srd_next", rename_instruction_0.prd, 34);
        check("srd_v", rename_valid, 1);

        // x0 destination
        do_reset();
        group(2'b11, mk(0, 1, 2), mk(7, 0, 3));
        tick();
        idle();
        check("x0_p0_prd", rename_instruction_0.prd, 0);
        check("x0_p0_old", rename_instruction_0.old_prd, 0);
        check("x0_p0_prs1", rename_instruction_0.prs1, 1);
        check("x0_p1_prs1", rename_instruction_1.prs1, 0);
        check("x0_p1_prd", rename_instruction_1.prd, 32);
        check("x0_p1_old", rename_instruction_1.old_prd, 7);
        check("x0_alloc", alloc_valid, 2);

        // exhaust free list
        do_reset();
        for (int g = 0; g < 16; g++) begin
            group(2'b11, mk(5, 0, 0), mk(6, 0, 0));
            tick();
        end
        check("ex_last0", rename_instruction_0.prd, 62);
        check("ex_last1", rename_instruction_1.prd, 63);
        group(2'b01, mk(7, 5, 0), mk(0, 0, 0));
        #1 check("ex_full", rename_ready, 0);
        tick();
        check("ex_held_v", rename_valid, 0);
        check("ex_held_r", rename_ready, 0);
        commit_valid = 2'b01;
        commit_rd_0 = 5'd5; commit_prd_0 = 6'd32; commit_old_prd_0 = 6'd5;
        #1 check("ex_same_cyc", rename_ready, 0);
        tick();
        commit_valid = 2'b00;
        #1 check("ex_freed", rename_ready, 1);
        tick();
        idle();
        check("ex_v", rename_valid, 1);
        check("ex_prd", rename_instruction_0.prd, 5);
        check("ex_old", rename_instruction_0.old_prd, 7);
        check("ex_prs1", rename_instruction_0.prs1, 62);

        // flush with same-cycle commit
        do_reset();
        group(2'b11, mk(1, 0, 0), mk(2, 0, 0));
        tick();
        group(2'b11, mk(1, 0, 0), mk(2, 0, 0));
        tick();
        group(2'b11, mk(3, 0, 0), mk(4, 0, 0));
        tick();
        check("fl_g3", rename_instruction_0.prd, 36);
        group(2'b11, mk(9, 0, 0), mk(9, 0, 0));
        commit_valid = 2'b11;
        commit_rd_0 = 5'd1; commit_prd_0 = 6'd32; commit_old_prd_0 = 6'd1;
        commit_rd_1 = 5'd2; commit_prd_1 = 6'd33; commit_old_prd_1 = 6'd2;
        flush = 1'b1;
        #1 check("fl_ready", rename_ready, 0);
        tick();
        idle();
        check("fl_valid", rename_valid, 0);
        group(2'b11, mk(5, 1, 2), mk(3, 3, 4));
        tick();
        idle();
        check("fl_p0_prs1", rename_instruction_0.prs1, 32);
        check("fl_p0_prs2", rename_instruction_0.prs2, 33);
        check("fl_p0_prd", rename_instruction_0.prd, 34);
        check("fl_p0_old", rename_instruction_0.old_prd, 5);
        check("fl_p1_prs1", rename_instruction_1.prs1, 3);
        check("fl_p1_prs2", rename_instruction_1.prs2, 4);
        check("fl_p1_prd", rename_instruction_1.prd, 35);
        check("fl_p1_old", rename_instruction_1.old_prd, 3);

        // reset mid-operation
        group(2'b11, mk(1, 0, 0), mk(2, 0, 0));
        commit_valid = 2'b11;
        commit_rd_0 = 5'd5; commit_prd_0 = 6'd34; commit_old_prd_0 = 6'd5;
        commit_rd_1 = 5'd3; commit_prd_1 = 6'd35; commit_old_prd_1 = 6'd3;
        rst = 1'b1;
        #1 check("mr_ready", rename_ready, 0);
        tick();
        rst = 1'b0;
        idle();
        check("mr_valid", rename_valid, 0);
        check("mr_alloc", alloc_valid, 0);
        check("mr_ins1", rename_instruction_1, 0);
        flush = 1'b1;
        tick();
        idle();
        group(2'b11, mk(1, 5, 3), mk(2, 1, 0));
        tick();
        idle();
        check("mr_rrat5", rename_instruction_0.prs1, 5);
        check("mr_rrat3", rename_instruction_0.prs2, 3);
        check("mr_prd0", rename_instruction_0.prd, 32);
        check("mr_old0", rename_instruction_0.old_prd, 1);
        check("mr_prs1b", rename_instruction_1.prs1, 32);
        check("mr_prd1", rename_instruction_1.prd, 33);
        check("mr_old1", rename_instruction_1.old_prd, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 Parameter ARCH_REGS, default 32, number of architectural registers (x0 hardwired zero).
REQ-002 Parameter PHY_REGS, default 64, number of physical registers.
REQ-003 Parameter PHY_WIDTH, default 6, physical tag width, log2(PHY_REGS).
REQ-004 Parameter ROB_WIDTH, default 4, ROB index width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 decode_valid  in  2  per-slot valid from decode; slot 0 is older.
REQ-009 decode_instruction_0/_1  in  instruction_t  decoded instructions; fields rd, rs1, rs2 are architectural.
REQ-010 rob_ready  in  1  ROB can accept two entries this cycle.
REQ-011 rob_id_0/_1  in  ROB_WIDTH  ROB indices for slots 0/1.
REQ-012 rename_ready  out  1  group accepted this cycle.
REQ-013 rename_valid  out  2  registered per-slot valid to dispatch.
REQ-014 rename_instruction_0/_1  out  instruction_t  renamed instructions; prs1, prs2, prd, old_prd filled.
REQ-015 rob_id_out_0/_1  out  ROB_WIDTH  registered ROB indices.
REQ-016 alloc_valid  out  2, alloc_prd_0/_1  out  PHY_WIDTH  newly allocated tags; PRF_valid bits clear on these.
REQ-017 commit_valid  in  2, commit_rd_0/_1  in  5, commit_prd_0/_1, commit_old_prd_0/_1  in  PHY_WIDTH  in-order retirement.
REQ-018 flush  in  1  mispredict/exception recovery.

Function
REQ-019 State: speculative RAT, retirement RAT (ARCH_REGS x PHY_WIDTH each), circular free list of PHY_REGS-ARCH_REGS entries, head, tail, committed_head pointers with wrap bit.
REQ-020 need = number of valid slots with rd!=0; rename_ready = !flush && rob_ready && (free_count >= need).
REQ-021 Group acceptance is atomic: both slots or neither; decode holds inputs while rename_ready=0.
REQ-022 Latency 1 cycle: an accepted group appears on rename_valid/rename_instruction next cycle; rename_valid=0 in any cycle following no acceptance.
REQ-023 Slot with rd!=0 pops the free-list head into prd; old_prd = current RAT[rd]; RAT[rd] <= prd.
REQ-024 rd==0: no pop, prd=0, old_prd=0, RAT unchanged.
REQ-025 prs1/prs2 = RAT[rs1]/RAT[rs2]; x0 always maps to p0.
REQ-026 Intra-group bypass: slot1 rs1/rs2 equal to slot0 rd (!=0) SHALL use slot0 prd.
REQ-027 Same-rd pair: slot1 old_prd = slot0 prd; RAT[rd] ends as slot1 prd.
REQ-028 Invalid slot0 with valid slot1: slot1 renames alone, no bypass.
REQ-029 Commit slot with commit_rd!=0: push commit_old_prd to tail, retirement RAT[rd] <= commit_prd, committed_head advances 1; slots processed in order 0 then 1.
REQ-030 Frees pushed in cycle N are allocatable from cycle N+1 only.
REQ-031 free_count = tail - head (wrap-bit arithmetic); never exceeds PHY_REGS-ARCH_REGS.
REQ-032 Flush: no acceptance; next cycle speculative RAT = retirement RAT including same-cycle commit updates; head = committed_head after same-cycle commits; rename_valid = 0.
REQ-033 Flush and commit in same cycle: commits fully applied before restore.

Reset
REQ-034 On rst: RAT and retirement RAT identity (arch i -> p i); free list holds p32..p63 in order; head=committed_head=0; tail=full; all outputs 0; rename_ready=0 during rst.
REQ-035 rst mid-operation discards in-flight group and pending commits.

Verification
REQ-036 After reset, group add x1,x2,x3 / add x4,x1,x1 -> slot0 prd=p32 old=p1; slot1 prs1=prs2=p32, prd=p33 old=p4; alloc_valid=2'b11.
REQ-037 Same rd: addi x5 / addi x5 -> slot0 prd=p32 old=p5; slot1 prd=p33 old=p32; RAT[5]=p33.
REQ-038 Exhaust: 16 groups of two rd!=0 -> free_count=0; next group rename_ready=0, held; one commit of old p5 -> accepted no earlier than cycle after commit if need<=1.
REQ-039 Rename 3 groups, commit 1st group, flush -> RAT[rd] equals committed tags; head rewound so next allocation reuses 2nd-group tags (p34).
REQ-040 rd=x0 group: slot0 rd=0, slot1 rd=7 -> slot0 prd=0, slot1 prd=p32, only alloc_valid[1]=1.
REQ-041 rst asserted with valid group and commits -> next cycle state equals REQ-034, rename_valid=0.
